// File: rtl/uart_rx_frame_deserializer.sv
`timescale 1ns/1ps
// UART receive deserializer: start/data/parity/stop FSM on an oversampling tick, valid/ready output.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit, decision moves to MID+1.
//
// state      | meaning
// IDLE       | line idle, waiting for a low sample
// START      | qualifying the start bit
// DATA       | shifting in data bits, LSB first
// PARITY     | checking the parity bit
// STOP       | sampling stop bit(s)
// WAIT_IDLE  | framing error seen, waiting for the line to return high
module uart_rx_frame_deserializer #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              baud_tick_i,
  input  logic              rxd_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  input  logic              overrun_clr_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_DEC = CNT_W'(MID + 1);
`else
  localparam logic [CNT_W-1:0] CNT_DEC = CNT_W'(MID);
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       IDX_LAST = 4'(DATA_W - 1);
  localparam logic             PAR_ODD  = 1'(PARITY == 2);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  logic              rxd_m, rxd_s;
  logic [2:0]        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        bit_idx;
  logic              stop_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_err, frm_err;
  logic              done_q;
  logic              bit_val;
  logic              at_dec, wrap, last_bit, last_stop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd_i;
      rxd_s <= rxd_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp_a, samp_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (baud_tick_i) begin
      if (cnt == CNT_W'(MID - 1)) samp_a <= rxd_s;
      if (cnt == CNT_W'(MID))     samp_b <= rxd_s;
    end
  end

  assign bit_val = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  assign at_dec    = (cnt == CNT_DEC);
  assign wrap      = (cnt == CNT_LAST);
  assign last_bit  = (bit_idx == IDX_LAST);
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  always_comb begin
    state_n = state;
    if (baud_tick_i) begin
      case (state)
        ST_IDLE:      if (!rxd_s) state_n = ST_START;
        ST_START: begin
          if (at_dec && bit_val) state_n = ST_IDLE;
          else if (wrap)         state_n = ST_DATA;
        end
        ST_DATA:      if (wrap && last_bit) state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
        ST_PARITY:    if (wrap) state_n = ST_STOP;
        // The last stop decision ends the frame immediately; no wait for the wrap.
        ST_STOP:      if (at_dec && last_stop) state_n = (frm_err | ~bit_val) ? ST_WAIT_IDLE : ST_IDLE;
        ST_WAIT_IDLE: if (rxd_s) state_n = ST_IDLE;
        default:      state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      busy_o   <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (baud_tick_i) begin
        state  <= state_n;
        busy_o <= (state_n != ST_IDLE);
        done_q <= (state == ST_STOP) && (state_n != ST_STOP);
        if (state_n != state || wrap || state == ST_IDLE || state == ST_WAIT_IDLE) cnt <= '0;
        else cnt <= cnt + 1'b1;
        case (state)
          ST_IDLE: begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
          end
          ST_DATA: begin
            if (at_dec) shreg <= {bit_val, shreg[DATA_W-1:1]};
            if (wrap && !last_bit) bit_idx <= bit_idx + 1'b1;
          end
          ST_PARITY: if (at_dec) par_err <= bit_val ^ (^shreg) ^ PAR_ODD;
          ST_STOP: begin
            if (at_dec) frm_err <= frm_err | ~bit_val;
            if (wrap) stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (done_q && (!valid_o || ready_i)) begin
        data_o       <= shreg;
        parity_err_o <= par_err;
        frame_err_o  <= frm_err;
        valid_o      <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      // A dropped frame outranks a clear in the same cycle.
      if (done_q && valid_o && !ready_i) overrun_o <= 1'b1;
      else if (overrun_clr_i)            overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
`timescale 1ns/1ps
// Randomised bench for uart_rx_frame_deserializer: line waveform built tick by tick from frame rules.
module tb_uart_rx_frame_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rxd = 1'b1;
  logic ready = 1'b0;
  logic oclr = 1'b0;
  int unsigned div = 0;

  logic [7:0] a_data, b_data;
  logic a_valid, a_pe, a_fe, a_ovr, a_busy;
  logic b_valid, b_pe, b_fe, b_ovr, b_busy;

  int total = 0;
  int bad = 0;
  logic line_q[$];
  logic [9:0] capa_q[$];
  logic [9:0] capb_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div  <= (div + 1) % 4;
    tick <= (div == 3);
  end

  uart_rx_frame_deserializer #(.DATA_W(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .rxd_i(rxd),
    .data_o(a_data), .valid_o(a_valid), .ready_i(ready),
    .parity_err_o(a_pe), .frame_err_o(a_fe), .overrun_o(a_ovr),
    .overrun_clr_i(oclr), .busy_o(a_busy));

  uart_rx_frame_deserializer #(.DATA_W(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .rxd_i(rxd),
    .data_o(b_data), .valid_o(b_valid), .ready_i(ready),
    .parity_err_o(b_pe), .frame_err_o(b_fe), .overrun_o(b_ovr),
    .overrun_clr_i(oclr), .busy_o(b_busy));

  // Every accepted word, as {parity_err, frame_err, data}.
  always @(posedge clk) begin
    if (!rst && a_valid && ready) capa_q.push_back({a_pe, a_fe, a_data});
    if (!rst && b_valid && ready) capb_q.push_back({b_pe, b_fe, b_data});
  end

  task automatic wait_tick();
    do @(posedge clk); while (!tick);
  endtask

  task automatic add_bit(input logic v);
    repeat (16) line_q.push_back(v);
  endtask

  // pmode: 0 none, 1 even, 2 odd; par_flip sends the wrong parity bit.
  task automatic build(input logic [7:0] d, input int pmode, input logic par_flip,
                       input int nstop, input logic [1:0] stops);
    add_bit(1'b0);
    for (int i = 0; i < 8; i++) add_bit(d[i]);
    if (pmode != 0) add_bit((^d) ^ (pmode == 2) ^ par_flip);
    for (int s = 0; s < nstop; s++) add_bit(stops[s]);
    add_bit(1'b1);
    add_bit(1'b1);
  endtask

  // Sample i of line_q is what the receiver sees on its i-th tick; arm raises ready when busy_a falls.
  task automatic drive(input int n, input bit arm, output bit armed);
    logic prev;
    prev  = a_busy;
    armed = 1'b0;
    for (int i = 0; i < n && line_q.size() > 0; i++) begin
      rxd = line_q.pop_front();
      wait_tick();
      #1;
      if (arm && !armed && prev && !a_busy) begin
        ready = 1'b1;
        armed = 1'b1;
      end
      prev = a_busy;
    end
  endtask

  task automatic run(input int n);
    bit dummy;
    drive(n, 1'b0, dummy);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ready = 1'b0; oclr = 1'b0; rxd = 1'b1;
    line_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    capa_q.delete();
    capb_q.delete();
    wait_tick(); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({a_data, a_valid, a_pe, a_fe, a_ovr, a_busy} !== 13'd0) begin
      bad++; $display("FAIL reset_a got=%h exp=0", {a_data, a_valid, a_pe, a_fe, a_ovr, a_busy});
    end
    total++;
    if ({b_data, b_valid, b_pe, b_fe, b_ovr, b_busy} !== 13'd0) begin
      bad++; $display("FAIL reset_b got=%h exp=0", {b_data, b_valid, b_pe, b_fe, b_ovr, b_busy});
    end
  endtask

  task automatic test_basic();
    do_reset();
    ready = 1'b1;
    build(8'hA5, 0, 1'b0, 1, 2'b11);
    run(80);
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid got=%b exp=1", a_busy); end
    run(10000);
    total++;
    if (capa_q.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", capa_q.size()); end
    else begin
      total++;
      if (capa_q[0] !== {2'b00, 8'hA5}) begin bad++; $display("FAIL basic_word got=%h exp=%h", capa_q[0], {2'b00, 8'hA5}); end
    end
    total++;
    if ({a_busy, a_valid} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b exp=00", {a_busy, a_valid}); end
  endtask

  task automatic test_false_start();
    do_reset();
    ready = 1'b0;
    repeat (4) line_q.push_back(1'b0);
    repeat (40) line_q.push_back(1'b1);
    run(6);
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL false_busy_mid got=%b exp=1", a_busy); end
    run(10000);
    total++;
    if ({a_busy, a_valid, a_ovr} !== 3'b000) begin
      bad++; $display("FAIL false_start got=%b exp=000", {a_busy, a_valid, a_ovr});
    end
  endtask

  task automatic test_parity();
    do_reset();
    ready = 1'b0;
    build(8'h07, 1, 1'b1, 2, 2'b11);
    run(10000);
    total++;
    if ({b_valid, b_pe, b_fe, b_data} !== {3'b110, 8'h07}) begin
      bad++; $display("FAIL parity_bad got=%b exp=%b", {b_valid, b_pe, b_fe, b_data}, {3'b110, 8'h07});
    end
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    build(8'h07, 1, 1'b0, 2, 2'b11);
    run(10000);
    total++;
    if ({b_valid, b_pe, b_fe, b_data} !== {3'b100, 8'h07}) begin
      bad++; $display("FAIL parity_good got=%b exp=%b", {b_valid, b_pe, b_fe, b_data}, {3'b100, 8'h07});
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    ready = 1'b1;
    repeat (13) add_bit(1'b0);
    repeat (3) add_bit(1'b1);
    run(13 * 16);
    total++;
    if (capa_q.size() != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", capa_q.size()); end
    else begin
      total++;
      if (capa_q[0] !== {2'b01, 8'h00}) begin bad++; $display("FAIL ferr_word got=%h exp=%h", capa_q[0], {2'b01, 8'h00}); end
    end
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL ferr_wait_busy got=%b exp=1", a_busy); end
    run(10000);
    total++;
    if ({a_busy, 6'(capa_q.size())} !== {1'b0, 6'd1}) begin
      bad++; $display("FAIL ferr_release got=%b/%0d exp=0/1", a_busy, capa_q.size());
    end
  endtask

  task automatic test_overrun();
    bit armed;
    do_reset();
    ready = 1'b0;
    build(8'h11, 0, 1'b0, 1, 2'b11);
    build(8'h22, 0, 1'b0, 1, 2'b11);
    run(10000);
    total++;
    if ({a_valid, a_ovr, a_data} !== {2'b11, 8'h11}) begin
      bad++; $display("FAIL ovr_set got=%b exp=%b", {a_valid, a_ovr, a_data}, {2'b11, 8'h11});
    end
    @(posedge clk); #1 ready = 1'b1; oclr = 1'b1;
    @(posedge clk); #1 ready = 1'b0; oclr = 1'b0;
    total++;
    if ({a_valid, a_ovr} !== 2'b00) begin bad++; $display("FAIL ovr_clear got=%b exp=00", {a_valid, a_ovr}); end
    capa_q.delete();
    build(8'h33, 0, 1'b0, 1, 2'b11);
    run(10000);
    build(8'h44, 0, 1'b0, 1, 2'b11);
    drive(10000, 1'b1, armed);
    total++;
    if (!armed) begin bad++; $display("FAIL ovr_arm got=0 exp=1"); end
    total++;
    if (capa_q.size() != 2) begin bad++; $display("FAIL ovr_coincide_count got=%0d exp=2", capa_q.size()); end
    else begin
      total++;
      if ({capa_q[0], capa_q[1]} !== {10'h033, 10'h044}) begin
        bad++; $display("FAIL ovr_coincide_words got=%h,%h exp=033,044", capa_q[0], capa_q[1]);
      end
    end
    total++;
    if (a_ovr !== 1'b0) begin bad++; $display("FAIL ovr_coincide_flag got=%b exp=0", a_ovr); end
    ready = 1'b0;
  endtask

  task automatic test_glitch();
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'h00;
`else
    exp_d = 8'h08;
`endif
    do_reset();
    ready = 1'b0;
    build(8'h00, 0, 1'b0, 1, 2'b11);
    line_q[73] = 1'b1;
    run(10000);
    total++;
    if ({a_valid, a_data} !== {1'b1, exp_d}) begin
      bad++; $display("FAIL glitch got=%b exp=%b", {a_valid, a_data}, {1'b1, exp_d});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0;
    build(8'h5A, 0, 1'b0, 1, 2'b11);
    build(8'h6B, 0, 1'b0, 1, 2'b11);
    build(8'h3C, 0, 1'b0, 1, 2'b11);
    run(2 * 176 + 70);
    total++;
    if ({a_valid, a_ovr, a_busy} !== 3'b111) begin bad++; $display("FAIL rstmid_pre got=%b exp=111", {a_valid, a_ovr, a_busy}); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({a_data, a_valid, a_pe, a_fe, a_ovr, a_busy} !== 13'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0", {a_data, a_valid, a_pe, a_fe, a_ovr, a_busy});
    end
    rst = 1'b0;
    rxd = 1'b1;
    line_q.delete();
    add_bit(1'b1);
    build(8'hC3, 0, 1'b0, 1, 2'b11);
    run(10000);
    total++;
    if ({a_valid, a_ovr, a_fe, a_data} !== {3'b100, 8'hC3}) begin
      bad++; $display("FAIL rstmid_next got=%b exp=%b", {a_valid, a_ovr, a_fe, a_data}, {3'b100, 8'hC3});
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic flip;
    logic [1:0] st;
    logic [9:0] got, exp_w;
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      build(d, 0, 1'b0, 1, st);
      run(10000);
      exp_w = {1'b0, ~st[0], d};
      total++;
      if (capa_q.size() == 0) begin bad++; $display("FAIL rand_a_missing k=%0d got=none exp=%h", k, exp_w); end
      else begin
        got = capa_q.pop_front();
        if (got !== exp_w) begin bad++; $display("FAIL rand_a k=%0d got=%h exp=%h", k, got, exp_w); end
      end
    end
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      st   = 2'($urandom_range(0, 3));
      build(d, 1, flip, 2, st);
      run(10000);
      exp_w = {flip, st != 2'b11, d};
      total++;
      if (capb_q.size() == 0) begin bad++; $display("FAIL rand_b_missing k=%0d got=none exp=%h", k, exp_w); end
      else begin
        got = capb_q.pop_front();
        if (got !== exp_w) begin bad++; $display("FAIL rand_b k=%0d got=%h exp=%h", k, got, exp_w); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
